// File: rtl/ram_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-port registered-address RAM among N_REQ requesters.
// Latency: fixed 4 cycles per access (IDLE, ISSUE, CAPTURE, RESP); ack pulses in RESP with read data.
// Backpressure: none; losers simply keep req high and are served in round-robin order.
module ram_arbiter #(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_we,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_wdata,
    output logic [N_REQ-1:0]          gnt,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rdata,
    output logic                      busy,
    output logic [DATA_W-1:0]         mem_data,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic                      mem_we,
    input  logic [DATA_W-1:0]         mem_q
);

    localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic [ID_W-1:0]     cmd_id_q, cmd_id_d;
    logic                cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
    logic [N_REQ-1:0]    gnt_q, gnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                win_vld;
    logic [ID_W-1:0]     win_id;

    // Round-robin pick: first pending requester after the last winner, wrapping around.
    always_comb begin
        logic [ID_W-1:0] idx;
        win_vld = 1'b0;
        win_id  = '0;
        idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_q) + k) % N_REQ);
            if (!win_vld && req[idx]) begin
                win_vld = 1'b1;
                win_id  = idx;
            end
        end
    end

    // State register plus latched command, grant and read data; all cleared by async reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= ID_W'(N_REQ - 1);
            cmd_id_q    <= '0;
            cmd_we_q    <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            gnt_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cmd_id_q    <= cmd_id_d;
            cmd_we_q    <= cmd_we_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            gnt_q       <= gnt_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next-state: leave IDLE only when someone is pending, then walk the fixed access sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_vld) state_d = ISSUE;
            ISSUE:   state_d = CAPTURE;
            CAPTURE: state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates: latch the winner's command at grant, grab RAM output in CAPTURE, drop grant after RESP.
    always_comb begin
        last_d      = last_q;
        cmd_id_d    = cmd_id_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        gnt_d       = gnt_q;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    last_d         = win_id;
                    cmd_id_d       = win_id;
                    cmd_we_d       = req_we[win_id];
                    cmd_addr_d     = req_addr[win_id * ADDR_W +: ADDR_W];
                    cmd_wdata_d    = req_wdata[win_id * DATA_W +: DATA_W];
                    gnt_d          = '0;
                    gnt_d[win_id]  = 1'b1;
                end
            end
            CAPTURE: rdata_d = mem_q;
            RESP:    gnt_d   = '0;
            default: ;
        endcase
    end

    // Outputs: write strobe only in ISSUE, ack only in RESP; address/data hold the latched command.
    always_comb begin
        ack = '0;
        if (state_q == RESP) begin
            ack[cmd_id_q] = 1'b1;
        end
        mem_we   = (state_q == ISSUE) && cmd_we_q;
        busy     = (state_q != IDLE);
        gnt      = gnt_q;
        rdata    = rdata_q;
        mem_addr = cmd_addr_q;
        mem_data = cmd_wdata_q;
    end

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_ack_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
    a_ack_gnt:    assert property (@(posedge clk) disable iff (!rst_n) ((ack & gnt) == ack));
    a_we_issue:   assert property (@(posedge clk) disable iff (!rst_n) (mem_we |-> (state_q == ISSUE)));

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter with four requesters and a registered-address RAM model.
// An access-level model (phase within the 4-cycle access, shadow memory) is checked every cycle.
// Directed scenarios add literal expectations for ids, read data, latency and period.
module tb_ram_arbiter;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    gnt;
    logic [N-1:0]    ack;
    logic [DW-1:0]   rdata;
    logic            busy;
    logic [DW-1:0]   mem_data;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [DW-1:0]   mem_q;

    ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .ack(ack),
        .rdata(rdata), .busy(busy), .mem_data(mem_data), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // Single-port RAM with registered address: q shows the word (including a fresh write) after the edge.
    logic [DW-1:0] ram [16] = '{default: '0};
    logic [AW-1:0] ram_addr_r = '0;
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_data;
        ram_addr_r <= mem_addr;
    end
    assign mem_q = ram[ram_addr_r];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int we_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Access-level model: which requester owns the RAM, how far into its 4-cycle access, and memory contents.
    int              m_phase = 0;
    int              m_last = N - 1;
    int              m_id = 0;
    int              m_c;
    bit              m_found;
    logic            m_we = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic [DW-1:0]   shadow [16] = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_last = N - 1; m_id = 0;
            m_we = 1'b0; m_addr = '0; m_wdata = '0;
        end else begin
            case (m_phase)
                0: if (req != '0) begin
                    m_found = 1'b0;
                    for (int k = 1; k <= N; k++) begin
                        m_c = (m_last + k) % N;
                        if (!m_found && req[m_c]) begin
                            m_found = 1'b1;
                            m_id    = m_c;
                        end
                    end
                    m_last  = m_id;
                    m_we    = req_we[m_id];
                    m_addr  = req_addr[m_id*AW +: AW];
                    m_wdata = req_wdata[m_id*DW +: DW];
                    m_phase = 1;
                end
                1: begin
                    if (m_we) shadow[m_addr] = m_wdata;
                    m_phase = 2;
                end
                2: m_phase = 3;
                default: m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison of every output against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic [N-1:0] e_gnt;
        logic [N-1:0] e_ack;
        e_gnt = (m_phase != 0) ? (N'(1) << m_id) : '0;
        e_ack = (m_phase == 3) ? (N'(1) << m_id) : '0;
        if (mem_we) we_cycles++;
        check("gnt", gnt, e_gnt);
        check("ack", ack, e_ack);
        check("busy", busy, m_phase != 0);
        check("mem_we", mem_we, (m_phase == 1) && m_we);
        check("mem_addr", mem_addr, m_addr);
        check("mem_data", mem_data, m_wdata);
        if (!rst_n) check("rdata_reset", rdata, 0);
        else if (e_ack != '0) check("rdata", rdata, shadow[m_addr]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]             = we;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req[i]                = 1'b1;
    endtask

    // Waits (bounded) for the next ack; reports the requester, data and cycle, and optionally releases req.
    task automatic collect_ack(input bit drop, output int id, output logic [DW-1:0] d, output int at);
        id = -1; d = '0; at = -1;
        for (int t = 0; t < 40 && id < 0; t++) begin
            @(negedge clk);
            if (ack != '0) begin
                for (int b = 0; b < N; b++) if (ack[b]) id = b;
                d  = rdata;
                at = cyc;
            end
        end
        if (id < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL ack_timeout: got no ack within 40 cycles, expected one (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
        if (drop && id >= 0) req[id] = 1'b0;
    endtask

    initial begin
        int            id;
        int            at;
        int            t0;
        int            w0;
        int            ids [4];
        int            ats [4];
        logic [DW-1:0] dat [4];
        logic [DW-1:0] d;
        int            g;

        // Reset state
        @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        tick();
        rst_n = 1'b1;

        // Reset lands during ISSUE of a write: strobe drops at once, nothing written, no ack
        set_cmd(0, 1'b1, 4'd3, 16'h1234);
        tick();
        check("t1_issue_we", mem_we, 1);
        #3 rst_n = 1'b0;
        #1;
        check("t1_we_async", mem_we, 0);
        check("t1_gnt_async", gnt, 0);
        check("t1_mem_data_async", mem_data, 0);
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
        set_cmd(1, 1'b0, 4'd3, 16'h0);
        collect_ack(1'b1, id, d, at);
        check("t1_readback_id", id, 1);
        check("t1_readback_data", d, 16'h0000);

        // Requester 0 writes 0xBEEF to addr 5; single-cycle strobe, ack in the third cycle after the request cycle
        w0 = we_cycles;
        t0 = cyc;
        set_cmd(0, 1'b1, 4'd5, 16'hBEEF);
        collect_ack(1'b1, id, d, at);
        check("t2_id", id, 0);
        check("t2_rdata", d, 16'hBEEF);
        check("t2_latency", at - t0, 3);
        check("t2_we_cycles", we_cycles - w0, 1);
        set_cmd(1, 1'b0, 4'd5, 16'h0);
        collect_ack(1'b1, id, d, at);
        check("t2_read_id", id, 1);
        check("t2_read_data", d, 16'hBEEF);

        // Read of an unwritten address returns zero without any write strobe
        w0 = we_cycles;
        set_cmd(2, 1'b0, 4'd15, 16'h0);
        collect_ack(1'b1, id, d, at);
        check("t3_id", id, 2);
        check("t3_rdata", d, 16'h0000);
        check("t3_no_we", we_cycles - w0, 0);

        // Two requesters hold req from reset: grants alternate, one access per IDLE+ISSUE+CAPTURE+RESP
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        set_cmd(0, 1'b0, 4'd1, 16'h0);
        set_cmd(1, 1'b1, 4'd1, 16'h00AA);
        for (int k = 0; k < 4; k++) begin
            collect_ack(1'b0, ids[k], dat[k], ats[k]);
        end
        req = '0;
        check("t4_id0", ids[0], 0);
        check("t4_id1", ids[1], 1);
        check("t4_id2", ids[2], 0);
        check("t4_id3", ids[3], 1);
        check("t4_rd0", dat[0], 16'h0000);
        check("t4_rd1", dat[1], 16'h00AA);
        check("t4_rd2", dat[2], 16'h00AA);
        check("t4_period", ats[2] - ats[1], 4);
        tick();

        // Last winner is 1: with 1 and 3 pending, 3 goes first, then 1
        set_cmd(1, 1'b0, 4'd2, 16'h0);
        set_cmd(3, 1'b0, 4'd3, 16'h0);
        collect_ack(1'b1, id, d, at);
        check("t5a_first", id, 3);
        collect_ack(1'b1, id, d, at);
        check("t5a_second", id, 1);

        // Same start, but requester 0 arrives during 3's access and is served before 1
        set_cmd(1, 1'b0, 4'd2, 16'h0);
        set_cmd(3, 1'b0, 4'd3, 16'h0);
        tick();
        set_cmd(0, 1'b0, 4'd4, 16'h0);
        collect_ack(1'b1, id, d, at);
        check("t5b_first", id, 3);
        collect_ack(1'b1, id, d, at);
        check("t5b_second", id, 0);
        collect_ack(1'b1, id, d, at);
        check("t5b_third", id, 1);

        // Requester drops req and changes addr during CAPTURE: latched command completes, no regrant
        set_cmd(2, 1'b0, 4'd5, 16'h0);
        tick();
        tick();
        req[2]             = 1'b0;
        req_addr[2*AW +: AW] = 4'd15;
        collect_ack(1'b0, id, d, at);
        check("t6_id", id, 2);
        check("t6_rdata", d, 16'hBEEF);
        g = 0;
        repeat (6) begin
            @(negedge clk);
            if (gnt != '0) g++;
        end
        check("t6_no_regrant", g, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete by 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
